// File: rtl/rs232rx_fifo.sv
// Receive-side byte FIFO for an RS-232 UART. It buffers bytes strobed in by
// the serial receiver, presents the head byte to a consumer through a
// valid/ready handshake, raises almost_full for RTS flow control, and keeps a
// sticky overflow flag when a byte had to be dropped.
module rs232rx_fifo #(
  parameter int DEPTH_LOG2    = 4,
  parameter int ALMOST_MARGIN = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [7:0]            out_data,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  almost_full,
  output logic                  overflow,
  input  logic                  clear_overflow
);

  localparam int DEPTH        = 2 ** DEPTH_LOG2;
  localparam int CW           = DEPTH_LOG2 + 1;
  localparam int ALMOST_LEVEL = DEPTH - ALMOST_MARGIN;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_reg;
  logic [DEPTH_LOG2-1:0] rd_ptr_reg;
  logic [DEPTH_LOG2-1:0] rd_addr_next;
  logic [CW-1:0]         count_reg;
  logic [CW-1:0]         count_next;
  logic                  overflow_reg;
  logic                  overflow_next;
  logic [7:0]            head_data_reg;
  logic                  full;
  logic                  pop;
  logic                  push;
  logic                  drop;

  // Status flags are pure functions of registered state.
  assign full        = (count_reg == DEPTH_C);
  assign out_valid   = (count_reg != '0);
  assign almost_full = (int'(count_reg) >= ALMOST_LEVEL);
  assign count       = count_reg;
  assign overflow    = overflow_reg;
  assign out_data    = out_valid ? head_data_reg : 8'h00;

  // A pop frees a slot in the same cycle, so a full FIFO can still accept.
  assign pop  = out_valid & out_ready;
  assign push = in_valid & (~full | pop);
  assign drop = in_valid & full & ~pop;

  // Address the head will live at after this edge.
  assign rd_addr_next = pop ? rd_ptr_reg + 1'b1 : rd_ptr_reg;

  // Occupancy and sticky overflow next-state; a drop beats a clear.
  always_comb begin
    count_next = count_reg;
    if (push && !pop) begin
      count_next = count_reg + CW'(1);
    end else if (pop && !push) begin
      count_next = count_reg - CW'(1);
    end
    overflow_next = overflow_reg;
    if (drop) begin
      overflow_next = 1'b1;
    end else if (clear_overflow) begin
      overflow_next = 1'b0;
    end
  end

  // Pointer, count and overflow state with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      rd_ptr_reg   <= rd_addr_next;
      count_reg    <= count_next;
      overflow_reg <= overflow_next;
    end
  end

  // Byte storage with a registered head read; a byte written to the slot
  // that becomes the head is forwarded, since the array read returns old data.
  always_ff @(posedge clock) begin
    if (push && !reset) begin
      mem[wr_ptr_reg] <= in_data;
    end
    if (push && !reset && (wr_ptr_reg == rd_addr_next)) begin
      head_data_reg <= in_data;
    end else begin
      head_data_reg <= mem[rd_addr_next];
    end
  end

endmodule

// File: tb/tb_rs232rx_fifo.sv
// Directed bench for rs232rx_fifo: a small occupancy/overflow model plus a
// queue of accepted bytes supplies every expected value.
module tb_rs232rx_fifo;

  localparam int DEPTH_LOG2 = 4;
  localparam int DEPTH      = 16;
  localparam int MARGIN     = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [DEPTH_LOG2:0] count;
  logic        almost_full;
  logic        overflow;
  logic        clear_overflow = 1'b0;

  int n_asserts = 0;
  int n_fail    = 0;

  // model state
  logic [7:0] sb_q[$];
  int         m_count = 0;
  logic       m_ovf   = 1'b0;

  always #5 clock = ~clock;

  rs232rx_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .ALMOST_MARGIN(MARGIN)) dut (
    .clock          (clock),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .out_ready      (out_ready),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .count          (count),
    .almost_full    (almost_full),
    .overflow       (overflow),
    .clear_overflow (clear_overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".count"}, 32'(count), 32'(m_count));
    chk({tag, ".almost_full"}, 32'(almost_full), 32'(m_count >= DEPTH - MARGIN));
    chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
  endtask

  // One clock cycle of stimulus, checked against the model on both sides of the edge.
  task automatic step(input logic iv, input logic [7:0] d, input logic rdy, input logic clr);
    logic pop_m, push_m, drop_m;
    logic [7:0] exp_b;
    in_valid = iv; in_data = d; out_ready = rdy; clear_overflow = clr;
    pop_m  = (m_count != 0) && rdy;
    push_m = iv && ((m_count != DEPTH) || pop_m);
    drop_m = iv && (m_count == DEPTH) && !pop_m;
    chk("out_valid", 32'(out_valid), 32'(m_count != 0));
    if (m_count == 0) chk("out_data_empty", 32'(out_data), 32'h0);
    if (pop_m) begin
      exp_b = sb_q.pop_front();
      chk("pop_data", 32'(out_data), 32'(exp_b));
    end
    if (push_m) sb_q.push_back(d);
    if (push_m && !pop_m) m_count++;
    else if (pop_m && !push_m) m_count--;
    if (drop_m) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    @(posedge clock);
    #1;
    in_valid = 1'b0; out_ready = 1'b0; clear_overflow = 1'b0;
    chk_state("post");
    $display("txn iv=%0b d=%02h rdy=%0b clr=%0b -> count=%0d out_valid=%0b out_data=%02h af=%0b ovf=%0b",
             iv, d, rdy, clr, count, out_valid, out_data, almost_full, overflow);
  endtask

  initial begin
    // reset values while held in reset
    #1;
    chk("rst.out_valid", 32'(out_valid), 32'h0);
    chk("rst.out_data", 32'(out_data), 32'h0);
    chk_state("rst");
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0;

    // single byte in and out
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    chk("a5.out_valid", 32'(out_valid), 32'h1);
    chk("a5.out_data", 32'(out_data), 32'hA5);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("a5.drained_data", 32'(out_data), 32'h0);

    // out_ready on an empty FIFO does nothing; push+ready while empty only pushes
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'h3E, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // fill, overflow, drain
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'hFF, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("drain.empty", 32'(out_valid), 32'h0);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // full with simultaneous push and pop
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    step(1'b1, 8'h55, 1'b1, 1'b0);
    chk("fullpp.count", 32'(count), 32'(DEPTH));
    chk("fullpp.ovf", 32'(overflow), 32'h0);

    // drop during clear wins, then clear alone
    step(1'b1, 8'h77, 1'b0, 1'b0);
    step(1'b1, 8'h78, 1'b0, 1'b1);
    chk("clr_drop.ovf", 32'(overflow), 32'h1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("clr.ovf", 32'(overflow), 32'h0);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    // streaming through several wraps
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 8'(8'h80 + i), 1'b1, 1'b0);
      n_asserts++;
      assert (count <= 1) else begin
        n_fail++;
        $error("FAIL stream.count observed=%0d expected<=1", count);
      end
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // asynchronous reset mid-operation
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("arst.out_valid", 32'(out_valid), 32'h0);
    chk("arst.out_data", 32'(out_data), 32'h0);
    chk("arst.count", 32'(count), 32'h0);
    chk("arst.almost_full", 32'(almost_full), 32'h0);
    sb_q.delete(); m_count = 0; m_ovf = 1'b0;
    in_valid = 1'b1; in_data = 8'hEE;
    @(posedge clock); #1;
    in_valid = 1'b0;
    chk("arst.ignore_in", 32'(count), 32'h0);
    reset = 1'b0;
    step(1'b1, 8'h3C, 1'b0, 1'b0);
    step(1'b1, 8'h3D, 1'b0, 1'b0);
    chk("arst.first", 32'(out_data), 32'h3C);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/rs232rx_fifo.md
RS232RX_FIFO -- requirements
Module: rs232rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 4, giving FIFO depth DEPTH = 2**DEPTH_LOG2 bytes.
REQ-002 SHALL have parameter ALMOST_MARGIN, default 2; almost_full asserts at count >= DEPTH - ALMOST_MARGIN.
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on posedge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  one-cycle strobe from the serial receiver marking a received byte.
REQ-006 SHALL have port in_data  input  8  received byte, qualified by in_valid.
REQ-007 SHALL have port out_ready  input  1  consumer accepts head byte this cycle.
REQ-008 SHALL have port out_valid  output  1  FIFO non-empty, out_data holds the head byte.
REQ-009 SHALL have port out_data  output  8  head byte; 8'h00 whenever out_valid = 0.
REQ-010 SHALL have port count  output  DEPTH_LOG2+1  current occupancy, 0..DEPTH.
REQ-011 SHALL have port almost_full  output  1  occupancy threshold flag for line flow control (RTS).
REQ-012 SHALL have port overflow  output  1  sticky: a byte was dropped because the FIFO was full.
REQ-013 SHALL have port clear_overflow  input  1  synchronous clear of overflow.

Function
REQ-014 SHALL store bytes in a DEPTH-entry memory with DEPTH_LOG2-bit write and read pointers, wrapping modulo DEPTH.
REQ-015 SHALL define push = in_valid & (count != DEPTH | pop), and pop = out_valid & out_ready.
REQ-016 On push, SHALL write in_data at the write pointer and advance it by 1.
REQ-017 On pop, SHALL advance the read pointer by 1.
REQ-018 SHALL update count: +1 on push only, -1 on pop only, unchanged on both or neither.
REQ-019 A pushed byte SHALL appear at out_data with out_valid = 1 on the cycle after the push edge, not before.
REQ-020 When empty, in_valid & out_ready in the same cycle SHALL push only; no pop occurs and out_valid remains 0 that cycle.
REQ-021 When full, in_valid together with pop SHALL accept the new byte; count stays DEPTH and overflow is not set.
REQ-022 When full, in_valid without pop SHALL drop the byte, leave memory, pointers, and count unchanged, and set overflow on the next edge.
REQ-023 overflow SHALL stay 1 until a cycle with clear_overflow = 1 and no new drop; a drop in the clear cycle SHALL win, and overflow stays 1.
REQ-024 out_ready while out_valid = 0 SHALL have no effect.
REQ-025 out_valid SHALL equal (count != 0), and almost_full SHALL equal (count >= DEPTH - ALMOST_MARGIN), both as registered-state functions with no combinational path from any input.
REQ-026 Byte order out SHALL equal accepted byte order in, across any number of pointer wrap-arounds.

Reset
REQ-027 Asserting reset SHALL immediately clear pointers, count, and overflow, forcing out_valid = 0, out_data = 8'h00, and almost_full = 0, independent of clock.
REQ-028 Reset mid-operation SHALL discard all stored bytes; memory contents need not be cleared.
REQ-029 in_valid arriving while reset is asserted SHALL be ignored.

Verification
REQ-030 Push 8'hA5 with out_ready = 0 -> next cycle out_valid = 1, out_data = 8'hA5, count = 1; then pulse out_ready -> next cycle out_valid = 0, out_data = 8'h00, count = 0.
REQ-031 Push 16 bytes 8'h00..8'h0F back-to-back (DEPTH = 16) -> count = 16, almost_full = 1 from count = 14; push 8'hFF -> overflow = 1, count = 16; drain -> 8'h00..8'h0F in order, 8'hFF never appears.
REQ-032 Full FIFO with in_valid = 8'h55 and out_ready in the same cycle -> count stays 16, overflow stays 0, 8'h55 emerges last after draining.
REQ-033 Stream 40 bytes with out_ready held 1 (pointers wrap twice) -> every byte out in order, each exactly once, count never exceeds 1.
REQ-034 overflow = 1, then clear_overflow in the same cycle as another drop -> overflow stays 1; clear_overflow alone -> overflow = 0.
REQ-035 Assert reset asynchronously between clock edges with count = 5 -> outputs reach reset values before the next edge, and after release the first pushed byte is the first read.
